// File: rtl/axi_sts_read_arbiter.sv
// axi_sts_read_arbiter: shares one AXI4-Lite read-only status slave
// between two masters, one read in flight, round-robin grant.
module axi_sts_read_arbiter #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,

  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,

  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,

  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t                    state;
  state_t                    state_nx;
  logic                      last_grant;
  logic                      last_grant_nx;
  logic                      grant;
  logic                      grant_nx;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg;
  logic [AXI_ADDR_WIDTH-1:0] addr_nx;
  logic [AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [AXI_DATA_WIDTH-1:0] rdata_nx;
  logic [1:0]                rresp_reg;
  logic [1:0]                rresp_nx;
  logic                      win0;
  logic                      win1;
  logic                      rsp_done;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      addr_reg   <= '0;
      rdata_reg  <= '0;
      rresp_reg  <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      grant      <= grant_nx;
      addr_reg   <= addr_nx;
      rdata_reg  <= rdata_nx;
      rresp_reg  <= rresp_nx;
    end
  end

  // On a tie the port not served last wins; the two wins are exclusive.
  always_comb begin
    win0 = s0_axi_arvalid & (~s1_axi_arvalid | last_grant);
    win1 = s1_axi_arvalid & (~s0_axi_arvalid | ~last_grant);
  end

  assign rsp_done = grant ? s1_axi_rready : s0_axi_rready;

  always_comb begin
    state_nx       = state;
    last_grant_nx  = last_grant;
    grant_nx       = grant;
    addr_nx        = addr_reg;
    rdata_nx       = rdata_reg;
    rresp_nx       = rresp_reg;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    unique case (state)
      IDLE: begin
        s0_axi_arready = win0;
        s1_axi_arready = win1;
        unique case (1'b1)
          win0: begin
            addr_nx  = s0_axi_araddr;
            grant_nx = 1'b0;
            state_nx = ADDR;
          end
          win1: begin
            addr_nx  = s1_axi_araddr;
            grant_nx = 1'b1;
            state_nx = ADDR;
          end
          default: ;
        endcase
      end
      ADDR: begin
        if (m_axi_arready) state_nx = DATA;
      end
      DATA: begin
        if (m_axi_rvalid) begin
          rdata_nx = m_axi_rdata;
          rresp_nx = m_axi_rresp;
          state_nx = RESP;
        end
      end
      RESP: begin
        if (rsp_done) begin
          last_grant_nx = grant;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Everything below is registered state only, no m_axi_* feedthrough.
  always_comb begin
    m_axi_araddr  = addr_reg;
    m_axi_arvalid = (state == ADDR);
    m_axi_rready  = (state == DATA);
    s0_axi_rdata  = rdata_reg;
    s0_axi_rresp  = rresp_reg;
    s0_axi_rvalid = (state == RESP) & ~grant;
    s1_axi_rdata  = rdata_reg;
    s1_axi_rresp  = rresp_reg;
    s1_axi_rvalid = (state == RESP) & grant;
    busy          = (state != IDLE);
  end

endmodule
